// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle sequencer for the EX-stage multiply (opcode 4'b0010) and divide
// (opcode 4'b0011). When such an op is accepted, the block stalls the pipeline.
// It then runs WIDTH iterations of an unsigned shift-add multiply or a
// restoring divide. The double-width result is presented for one cycle
// together with done, and the stall is released. Any other opcode passes
// through without interaction.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        EX-stage instruction valid this cycle
//   opcode[3:0]  ALU op field of the EX-stage instruction
//   a, b         unsigned operands (multiplicand/dividend, multiplier/divisor)
//   stall        hold IF/ID/EX pipeline registers (combinational)
//   busy         sequencer is not idle
//   done         one-cycle pulse, results valid
//   result_lo    product low half / quotient
//   result_hi    product high half / remainder
//   div_by_zero  set with done when the divide had b == 0
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  // hi/lo hold {product high, product low} for multiply, {rem, quot} for divide.
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             dbz_q,    dbz_d;

  logic             is_muldiv;
  logic             accept;
  logic             last_iter;

  // Multiply step: add with carry-out, then shift {carry,hi,lo} right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  // Divide step: the shifted remainder needs one extra bit before the compare.
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem, div_quot;

  logic [WIDTH-1:0] iter_hi, iter_lo;

  // NOTE: every signal assigned in this block gets a default first, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;

    is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    accept    = (state_q == S_IDLE) && start && is_muldiv;
    last_iter = (count_q == CW'(WIDTH - 1));

    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    // The true remainder is below b, so the low WIDTH bits of the difference
    // are exact.
    div_diff = div_sh[WIDTH-1:0] - opb_q;
    div_rem  = div_ge ? div_diff : div_sh[WIDTH-1:0];
    div_quot = {lo_q[WIDTH-2:0], div_ge};

    iter_hi = is_div_q ? div_rem  : mul_hi;
    iter_lo = is_div_q ? div_quot : mul_lo;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d = (opcode == OP_DIV);
          opb_d    = b;
          count_d  = '0;
          if ((opcode == OP_DIV) && (b == '0)) begin
            // Divide by zero skips the iterations entirely.
            state_d  = S_DONE;
            res_lo_d = '1;
            res_hi_d = a;
            dbz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
            hi_d    = '0;
            lo_d    = a;
          end
        end
      end
      S_RUN: begin
        hi_d = iter_hi;
        lo_d = iter_lo;
        if (last_iter) begin
          state_d  = S_DONE;
          count_d  = '0;
          res_lo_d = iter_lo;
          res_hi_d = iter_hi;
          dbz_d    = 1'b0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_DONE: begin
        // The instruction that caused this op is still in EX with start high;
        // returning to IDLE without looking at start prevents a re-accept.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop. All registers, including the
  // datapath and result holding registers, are reset so that an aborted
  // operation never leaves a partial result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      is_div_q <= 1'b0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign stall       = accept || (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer (WIDTH = 16). A behavioural model keeps
// the expected outputs using plain arithmetic and a countdown of remaining
// busy cycles. A compare process checks every output on each falling edge.
// The stimulus adds hand-computed literal expectations for results, done
// cycle and stall length.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 16;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] a, b;
  logic         stall, busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  // left = cycles the op still keeps the block busy (0 = idle, 1 = done cycle).
  int           m_left;
  logic [W-1:0] m_lo, m_hi, p_lo, p_hi;
  logic         m_dbz;
  logic         m_acc;

  always_comb m_acc = (m_left == 0) && start && (opcode == OP_MUL || opcode == OP_DIV);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_lo <= '0; m_hi <= '0; m_dbz <= 1'b0;
      p_lo <= '0; p_hi <= '0;
    end else if (m_left == 0) begin
      if (m_acc) begin
        if (opcode == OP_DIV && b == '0) begin
          m_lo <= '1; m_hi <= a; m_dbz <= 1'b1;
          m_left <= 1;
        end else begin
          if (opcode == OP_DIV) begin
            p_lo <= a / b;
            p_hi <= a % b;
          end else begin
            {p_hi, p_lo} <= 32'(a) * 32'(b);
          end
          m_left <= W + 1;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_lo <= p_lo; m_hi <= p_hi; m_dbz <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("stall",       32'(stall),       32'(m_acc || (m_left > 1)));
      check("busy",        32'(busy),        32'(m_left != 0));
      check("done",        32'(done),        32'(m_left == 1));
      check("result_lo",   32'(result_lo),   32'(m_lo));
      check("result_hi",   32'(result_hi),   32'(m_hi));
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Called at posedge+1 of the accept cycle. Returns at posedge+1 of the cycle
  // after done, with start dropped. hold keeps the instruction in EX until done.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit hold, output int done_cyc, output int stall_cyc);
    start = 1'b1; opcode = op; a = av; b = bv;
    done_cyc = -1; stall_cyc = 0;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (stall) stall_cyc++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      if (!hold) begin
        start = 1'b0; opcode = 4'b0000; a = 16'($urandom); b = 16'($urandom);
      end
    end
    if (done_cyc < 0) check("done_timeout", 32'(done_cyc), 32'd17);
    @(posedge clk); #1;
    start = 1'b0; opcode = 4'b0000;
  endtask

  int dc, sc, dc2, sc2, done_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 4'b0000; a = '0; b = '0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_res",   {result_hi, result_lo}, 32'd0);
    check("rst_dbz",   32'(div_by_zero), 32'd0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL 3 x 5
    run_op(OP_MUL, 16'd3, 16'd5, 1'b0, dc, sc);
    check("mul3x5_done_cyc", 32'(dc), 32'd17);
    check("mul3x5_stall_cyc", 32'(sc), 32'd17);
    check("mul3x5_res", {result_hi, result_lo}, 32'h0000_000F);
    check("mul3x5_dbz", 32'(div_by_zero), 32'd0);

    // MUL 0xFFFF x 0xFFFF (carry path)
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, dc, sc);
    check("mulmax_res", {result_hi, result_lo}, 32'hFFFE_0001);

    // DIV 100 / 7
    run_op(OP_DIV, 16'h0064, 16'h0007, 1'b0, dc, sc);
    check("div100_7_done_cyc", 32'(dc), 32'd17);
    check("div100_7_res", {result_hi, result_lo}, 32'h0002_000E);

    // DIV 0x1234 / 0
    run_op(OP_DIV, 16'h1234, 16'h0000, 1'b0, dc, sc);
    check("dbz_done_cyc", 32'(dc), 32'd1);
    check("dbz_stall_cyc", 32'(sc), 32'd1);
    check("dbz_res", {result_hi, result_lo}, 32'h1234_FFFF);
    check("dbz_flag", 32'(div_by_zero), 32'd1);

    // Non-muldiv opcodes pass through
    begin
      logic [3:0] ops [3];
      ops[0] = 4'b0000; ops[1] = 4'b0101; ops[2] = 4'b1001;
      for (int i = 0; i < 3; i++) begin
        start = 1'b1; opcode = ops[i]; a = 16'($urandom); b = 16'($urandom);
        @(negedge clk);
        check("pass_stall", 32'(stall), 32'd0);
        check("pass_busy",  32'(busy),  32'd0);
        check("pass_done",  32'(done),  32'd0);
        check("pass_res",   {result_hi, result_lo}, 32'h1234_FFFF);
        @(posedge clk); #1;
      end
      start = 1'b0;
    end

    // start held through DONE: no re-accept
    run_op(OP_MUL, 16'd7, 16'd9, 1'b1, dc, sc);
    check("hold_done_cyc", 32'(dc), 32'd17);
    @(negedge clk);
    check("hold_busy_after", 32'(busy), 32'd0);
    check("hold_res", {result_hi, result_lo}, 32'd63);
    @(posedge clk); #1;

    // Reset in cycle 8 of a MUL
    start = 1'b1; opcode = OP_MUL; a = 16'h00AB; b = 16'h00CD;
    @(posedge clk); #1;
    start = 1'b0; opcode = 4'b0000;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_done",  32'(done),  32'd0);
    check("arst_res",   {result_hi, result_lo}, 32'd0);
    check("arst_dbz",   32'(div_by_zero), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    @(posedge clk); #1;
    run_op(OP_DIV, 16'd9, 16'd2, 1'b0, dc, sc);
    check("div9_2_done_cyc", 32'(dc), 32'd17);
    check("div9_2_res", {result_hi, result_lo}, 32'h0001_0004);

    // Back-to-back MUL 2x3 then DIV 7/3 (second accepted at cycle 18)
    run_op(OP_MUL, 16'd2, 16'd3, 1'b0, dc, sc);
    check("b2b_mul_done_cyc", 32'(dc), 32'd17);
    check("b2b_mul_res", {result_hi, result_lo}, 32'd6);
    run_op(OP_DIV, 16'd7, 16'd3, 1'b0, dc2, sc2);
    check("b2b_div_done_cyc", 32'(18 + dc2), 32'd35);
    check("b2b_div_stall_cyc", 32'(sc2), 32'd17);
    check("b2b_div_res", {result_hi, result_lo}, 32'h0001_0002);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
